// File: rtl/inc_dec_pkg.sv
// ============================================================================
//  Module      : inc_dec_pkg
//  Description : Shared constants and helpers for the parametrised up/down
//                counter: boundary-mode encodings, a bound clamp and the
//                counting-range helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inc_dec_pkg;

    // Boundary-mode encodings for the WRAP parameter
    localparam int MODE_SAT  = 0;
    localparam int MODE_WRAP = 1;

    // Clamp a value into [lo, hi]; values are zero-extended to 32 bits
    function automatic logic [31:0] clamp(
        input logic [31:0] v,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        logic [31:0] r;
        r = v;
        if (v < lo) r = lo;
        if (v > hi) r = hi;
        return r;
    endfunction

    // Number of distinct counter values, hi - lo + 1.
    // 33 bits so that a full 32-bit range (2**32) is representable.
    function automatic logic [32:0] range_of(
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return {1'b0, hi} - {1'b0, lo} + 33'd1;
    endfunction

endpackage : inc_dec_pkg

`default_nettype wire

// File: rtl/inc_dec_edge_det.sv
// ============================================================================
//  Module      : inc_dec_edge_det
//  Description : 1-bit rising-edge detector with synchronous active-low reset.
//  Ports       : clk    - clock
//                rst    - synchronous active-low reset (clears history)
//                d_i    - level input
//                rise_o - high in the cycle d_i is 1 and was 0 last cycle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inc_dec_edge_det
    import inc_dec_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    // History cleared by reset, so a level high across reset release counts
    assign rise_o = d_i & ~d_q;

endmodule : inc_dec_edge_det

`default_nettype wire

// File: rtl/inc_dec_counter_param.sv
// ============================================================================
//  Module      : inc_dec_counter_param
//  Description : Parametrised up/down counter with configurable width, step,
//                bounds, saturate-or-wrap mode, synchronous load, enable,
//                bound flags and overflow/underflow pulses.
//                Optional macro INC_DEC_COUNTER_EDGE_DETECT_EN: when defined,
//                inc/dec count once per rising edge instead of per high cycle.
//  Ports       : clk      - clock, rising edge
//                rst      - synchronous active-low reset
//                en       - count enable (load honoured regardless)
//                inc/dec  - increment / decrement requests
//                load     - synchronous load of load_val (clamped to bounds)
//                load_val - value to load
//                cnt      - registered count
//                at_max   - cnt == MAX_VAL (combinational)
//                at_min   - cnt == MIN_VAL (combinational)
//                ovf/unf  - registered 1-cycle overflow / underflow pulses
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inc_dec_counter_param
    import inc_dec_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH:0]   STEP    = 1,
    parameter logic [WIDTH-1:0] MIN_VAL = '0,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter int               WRAP    = MODE_SAT,
    parameter logic [WIDTH-1:0] RST_VAL = MIN_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH:0] c_RANGE =
        (WIDTH+1)'(range_of(32'(MIN_VAL), 32'(MAX_VAL)));

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             w_inc_eff;
    logic             w_dec_eff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_load_clamped;

`ifdef INC_DEC_COUNTER_EDGE_DETECT_EN
    inc_dec_edge_det u_inc_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (inc),
        .rise_o (w_inc_eff)
    );

    inc_dec_edge_det u_dec_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (dec),
        .rise_o (w_dec_eff)
    );
`else
    assign w_inc_eff = inc;
    assign w_dec_eff = dec;
`endif

    // One extra bit so neither direction can silently truncate; w_diff is
    // read as signed so a step below zero compares as negative.
    assign w_sum          = {1'b0, cnt_q} + STEP;
    assign w_diff         = {1'b0, cnt_q} - STEP;
    assign w_load_clamped = WIDTH'(clamp(32'(load_val), 32'(MIN_VAL), 32'(MAX_VAL)));

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (load) begin
            cnt_d = w_load_clamped;
        end else if (!en) begin
            cnt_d = cnt_q;
        end else if (w_inc_eff && w_dec_eff) begin
            cnt_d = cnt_q;
        end else if (w_inc_eff) begin
            if (w_sum <= {1'b0, MAX_VAL}) begin
                cnt_d = WIDTH'(w_sum);
            end else begin
                ovf_d = 1'b1;
                // sum - range == MIN_VAL + (sum - MAX_VAL - 1)
                cnt_d = (WRAP == MODE_WRAP) ? WIDTH'(w_sum - c_RANGE) : MAX_VAL;
            end
        end else if (w_dec_eff) begin
            if ($signed(w_diff) >= $signed({1'b0, MIN_VAL})) begin
                cnt_d = WIDTH'(w_diff);
            end else begin
                unf_d = 1'b1;
                // diff + range == MAX_VAL - (MIN_VAL - diff - 1)
                cnt_d = (WRAP == MODE_WRAP) ? WIDTH'(w_diff + c_RANGE) : MIN_VAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= RST_VAL;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign cnt    = cnt_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign at_max = (cnt_q == MAX_VAL);
    assign at_min = (cnt_q == MIN_VAL);

endmodule : inc_dec_counter_param

`default_nettype wire

// File: tb/tb_inc_dec_counter_param.sv
// ============================================================================
//  Module      : tb_inc_dec_counter_param
//  Description : Directed self-checking bench for inc_dec_counter_param.
//                Three instances share stimulus: default parameters, a
//                wrapping STEP=3 [2..12] counter and a saturating [0..12]
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inc_dec_counter_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic       inc;
    logic       dec;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] d_cnt, w_cnt, s_cnt;
    logic       d_max, d_min, d_ovf, d_unf;
    logic       w_max, w_min, w_ovf, w_unf;
    logic       s_max, s_min, s_ovf, s_unf;

    int total;
    int bad;

    inc_dec_counter_param u_def (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec),
        .load(load), .load_val(load_val),
        .cnt(d_cnt), .at_max(d_max), .at_min(d_min), .ovf(d_ovf), .unf(d_unf)
    );

    inc_dec_counter_param #(
        .WIDTH(4), .STEP(5'd3), .MIN_VAL(4'd2), .MAX_VAL(4'd12),
        .WRAP(1), .RST_VAL(4'd2)
    ) u_wrap (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec),
        .load(load), .load_val(load_val),
        .cnt(w_cnt), .at_max(w_max), .at_min(w_min), .ovf(w_ovf), .unf(w_unf)
    );

    inc_dec_counter_param #(
        .WIDTH(4), .MAX_VAL(4'd12), .WRAP(0)
    ) u_sat12 (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec),
        .load(load), .load_val(load_val),
        .cnt(s_cnt), .at_max(s_max), .at_min(s_min), .ovf(s_ovf), .unf(s_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1; load_val = v;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; inc = 1'b1; dec = 1'b0; load = 1'b0; load_val = '0;
        step();
        step();
        total++; if (d_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt actual=%0d required=0", d_cnt); end
        total++; if ({d_ovf, d_unf} !== 2'b00) begin bad++; $display("FAIL reset_pulses actual=%b required=00", {d_ovf, d_unf}); end
        total++; if (w_cnt !== 4'd2) begin bad++; $display("FAIL reset_wrap_cnt actual=%0d required=2", w_cnt); end
        rst = 1'b1;
        step();
        total++; if (d_cnt !== 4'd1) begin bad++; $display("FAIL reset_resume actual=%0d required=1", d_cnt); end
        inc = 1'b0;
        step();
    endtask

    task automatic test_saturate_inc();
        do_load(4'd0);
        step();
        for (int i = 1; i <= 15; i++) begin
            inc = 1'b1; step(); inc = 1'b0;
            if (i == 15) begin
                total++; if (d_cnt !== 4'd15 || d_ovf !== 1'b0) begin bad++; $display("FAIL inc15 actual cnt=%0d ovf=%b required cnt=15 ovf=0", d_cnt, d_ovf); end
            end
            step();
        end
        total++; if (d_max !== 1'b1) begin bad++; $display("FAIL at_max15 actual=%b required=1", d_max); end
        inc = 1'b1; step(); inc = 1'b0;
        total++; if (d_cnt !== 4'd15 || d_ovf !== 1'b1) begin bad++; $display("FAIL inc16 actual cnt=%0d ovf=%b required cnt=15 ovf=1", d_cnt, d_ovf); end
        step();
        total++; if (d_ovf !== 1'b0) begin bad++; $display("FAIL ovf_one_cycle actual=%b required=0", d_ovf); end
        for (int i = 0; i < 5; i++) begin
            dec = 1'b1; step(); dec = 1'b0; step();
        end
        total++; if (d_cnt !== 4'd10 || d_unf !== 1'b0) begin bad++; $display("FAIL dec5 actual cnt=%0d unf=%b required cnt=10 unf=0", d_cnt, d_unf); end
    endtask

    task automatic test_wrap();
        do_load(4'd11);
        inc = 1'b1; step(); inc = 1'b0;
        total++; if (w_cnt !== 4'd3 || w_ovf !== 1'b1) begin bad++; $display("FAIL wrap_inc actual cnt=%0d ovf=%b required cnt=3 ovf=1", w_cnt, w_ovf); end
        step();
        do_load(4'd3);
        dec = 1'b1; step(); dec = 1'b0;
        total++; if (w_cnt !== 4'd11 || w_unf !== 1'b1) begin bad++; $display("FAIL wrap_dec actual cnt=%0d unf=%b required cnt=11 unf=1", w_cnt, w_unf); end
        step();
        // Plain in-range step: 8 + 3 = 11, no pulse
        do_load(4'd8);
        inc = 1'b1; step(); inc = 1'b0;
        total++; if (w_cnt !== 4'd11 || w_ovf !== 1'b0) begin bad++; $display("FAIL wrap_inrange actual cnt=%0d ovf=%b required cnt=11 ovf=0", w_cnt, w_ovf); end
        step();
        // Load below MIN_VAL clamps up to 2
        do_load(4'd0);
        total++; if (w_cnt !== 4'd2 || w_min !== 1'b1) begin bad++; $display("FAIL wrap_clamp_lo actual cnt=%0d at_min=%b required cnt=2 at_min=1", w_cnt, w_min); end
    endtask

    task automatic test_priority();
        do_load(4'd7);
        inc = 1'b1; dec = 1'b1; step(); inc = 1'b0; dec = 1'b0;
        total++; if (s_cnt !== 4'd7 || {s_ovf, s_unf} !== 2'b00) begin bad++; $display("FAIL cancel actual cnt=%0d pulses=%b required cnt=7 pulses=00", s_cnt, {s_ovf, s_unf}); end
        step();
        load = 1'b1; load_val = 4'd9; inc = 1'b1; step(); load = 1'b0; inc = 1'b0;
        total++; if (s_cnt !== 4'd9) begin bad++; $display("FAIL load_over_inc actual=%0d required=9", s_cnt); end
        step();
        do_load(4'd14);
        total++; if (s_cnt !== 4'd12 || s_max !== 1'b1) begin bad++; $display("FAIL clamp_hi actual cnt=%0d at_max=%b required cnt=12 at_max=1", s_cnt, s_max); end
        do_load(4'd5);
        en = 1'b0; inc = 1'b1; step(); inc = 1'b0;
        total++; if (s_cnt !== 4'd5 || s_ovf !== 1'b0) begin bad++; $display("FAIL en_hold actual cnt=%0d ovf=%b required cnt=5 ovf=0", s_cnt, s_ovf); end
        // Load is still honoured while disabled
        load = 1'b1; load_val = 4'd4; step(); load = 1'b0;
        total++; if (s_cnt !== 4'd4) begin bad++; $display("FAIL load_when_disabled actual=%0d required=4", s_cnt); end
        en = 1'b1;
        step();
    endtask

    task automatic test_sat_underflow();
        do_load(4'd0);
        total++; if (d_min !== 1'b1) begin bad++; $display("FAIL at_min_before actual=%b required=1", d_min); end
        dec = 1'b1; step(); dec = 1'b0;
        total++; if (d_cnt !== 4'd0 || d_unf !== 1'b1 || d_min !== 1'b1) begin bad++; $display("FAIL sat_unf actual cnt=%0d unf=%b at_min=%b required cnt=0 unf=1 at_min=1", d_cnt, d_unf, d_min); end
        step();
        total++; if (d_unf !== 1'b0 || d_min !== 1'b1) begin bad++; $display("FAIL unf_one_cycle actual unf=%b at_min=%b required unf=0 at_min=1", d_unf, d_min); end
    endtask

    task automatic test_edge_mode();
        logic [3:0] exp_cnt;
`ifdef INC_DEC_COUNTER_EDGE_DETECT_EN
        exp_cnt = 4'd3;
`else
        exp_cnt = 4'd7;
`endif
        do_load(4'd2);
        inc = 1'b1;
        for (int i = 0; i < 5; i++) step();
        inc = 1'b0;
        total++; if (d_cnt !== exp_cnt) begin bad++; $display("FAIL inc_held actual=%0d required=%0d", d_cnt, exp_cnt); end
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_saturate_inc();
        test_wrap();
        test_priority();
        test_sat_underflow();
        test_edge_mode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_inc_dec_counter_param

`default_nettype wire
